// File: rtl/cv_countacc.sv
// cv_countacc: frame accumulator for per-word bit counts.
// Sums in_cnt over the accepted beats of a frame (closed by in_last), counts
// the beats, and presents saturating totals on a held valid/ready output.
module cv_countacc #(
  parameter int CSIZE = 3,
  parameter int ASIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CSIZE-1:0] in_cnt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE-1:0] out_sum,
  output logic [ASIZE-1:0] out_beats,
  output logic             out_sat
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [ASIZE-1:0] ACC_MAX = {ASIZE{1'b1}};

  state_e           state_q;
  logic [ASIZE-1:0] acc_sum_q;
  logic [ASIZE-1:0] acc_beats_q;
  logic             acc_sat_q;
  logic [ASIZE-1:0] out_sum_q;
  logic [ASIZE-1:0] out_beats_q;
  logic             out_sat_q;

  logic [ASIZE:0]   sum_ext_s;
  logic [ASIZE:0]   beats_ext_s;
  logic [ASIZE-1:0] sum_d;
  logic [ASIZE-1:0] beats_d;
  logic             sat_d;

  // Saturating add. Returns {overflow, result}; on overflow the result is
  // clamped to the all-ones maximum, so a clamped value stays clamped.
  function automatic logic [ASIZE:0] sat_add(input logic [ASIZE-1:0] a,
                                             input logic [ASIZE:0]   b);
    logic [ASIZE:0] raw;
    raw = {1'b0, a} + b;
    if (raw[ASIZE]) begin
      sat_add = {1'b1, ACC_MAX};
    end else begin
      sat_add = raw;
    end
  endfunction

  // Handshake flags are decoded from state only (no input-to-output path).
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;

  // Next accumulator values if the current beat is accepted.
  always_comb begin
    sum_ext_s   = sat_add(acc_sum_q, {{(ASIZE + 1 - CSIZE){1'b0}}, in_cnt});
    beats_ext_s = sat_add(acc_beats_q, {{ASIZE{1'b0}}, 1'b1});
    sum_d       = sum_ext_s[ASIZE-1:0];
    beats_d     = beats_ext_s[ASIZE-1:0];
    sat_d       = acc_sat_q | sum_ext_s[ASIZE] | beats_ext_s[ASIZE];
  end

  // Frame FSM: accumulate in ACC, present and hold the result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_sum_q   <= {ASIZE{1'b0}};
      acc_beats_q <= {ASIZE{1'b0}};
      acc_sat_q   <= 1'b0;
      out_sum_q   <= {ASIZE{1'b0}};
      out_beats_q <= {ASIZE{1'b0}};
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (in_last) begin
              // Closing beat: its own count is included in the result.
              out_sum_q   <= sum_d;
              out_beats_q <= beats_d;
              out_sat_q   <= sat_d;
              acc_sum_q   <= {ASIZE{1'b0}};
              acc_beats_q <= {ASIZE{1'b0}};
              acc_sat_q   <= 1'b0;
              state_q     <= ST_HOLD;
            end else begin
              acc_sum_q   <= sum_d;
              acc_beats_q <= beats_d;
              acc_sat_q   <= sat_d;
            end
          end
        end
        ST_HOLD: begin
          // Result registers keep their values after transfer.
          if (out_ready) begin
            state_q <= ST_ACC;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv_countacc.sv
// Testbench for cv_countacc. Two instances share the handshake stimulus:
// dut_a (CSIZE=4, ASIZE=16) and dut_b (CSIZE=3, ASIZE=4, fed in_cnt[2:0])
// so narrow-width saturation is exercised alongside the wide case.
module tb_cv_countacc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_cnt;
  logic        in_last;
  logic        out_ready;
  logic [2:0]  cnt_b;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_sum_a, out_beats_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [3:0]  out_sum_b, out_beats_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign cnt_b = in_cnt[2:0];

  always #5 clk = ~clk;

  cv_countacc #(.CSIZE(4), .ASIZE(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_beats(out_beats_a),
    .out_sat(out_sat_a)
  );

  cv_countacc #(.CSIZE(3), .ASIZE(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_cnt(cnt_b), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_beats(out_beats_b),
    .out_sat(out_sat_b)
  );

  typedef struct {
    bit r; bit v; int cnt; bit last; bit ordy;
    bit e_rdy; bit e_ov;
    int e_sa; int e_ba; bit e_sata;
    int e_sb; int e_bb; bit e_satb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit rdy, input bit ov,
                           input int sa, input int ba, input bit sata,
                           input int sb, input int bb, input bit satb);
    chk({tag, " a.in_ready"},  32'(in_ready_a),  32'(rdy));
    chk({tag, " a.out_valid"}, 32'(out_valid_a), 32'(ov));
    chk({tag, " a.out_sum"},   32'(out_sum_a),   sa);
    chk({tag, " a.out_beats"}, 32'(out_beats_a), ba);
    chk({tag, " a.out_sat"},   32'(out_sat_a),   32'(sata));
    chk({tag, " b.in_ready"},  32'(in_ready_b),  32'(rdy));
    chk({tag, " b.out_valid"}, 32'(out_valid_b), 32'(ov));
    chk({tag, " b.out_sum"},   32'(out_sum_b),   sb);
    chk({tag, " b.out_beats"}, 32'(out_beats_b), bb);
    chk({tag, " b.out_sat"},   32'(out_sat_b),   32'(satb));
  endtask

  function automatic vec_t mk(bit r, bit v, int cnt, bit last, bit ordy,
                              bit e_rdy, bit e_ov, int e_sa, int e_ba, bit e_sata,
                              int e_sb, int e_bb, bit e_satb);
    vec_t t;
    t.r = r; t.v = v; t.cnt = cnt; t.last = last; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_ov = e_ov;
    t.e_sa = e_sa; t.e_ba = e_ba; t.e_sata = e_sata;
    t.e_sb = e_sb; t.e_bb = e_bb; t.e_satb = e_satb;
    return t;
  endfunction

  // Reference model state: pending-result flag, beats of the open frame,
  // and the last presented result for each width.
  bit   m_hold;
  int   m_frame[$];
  int   m_sa, m_ba, m_sb, m_bb;
  bit   m_sata, m_satb;

  task automatic model_reset();
    m_hold = 1'b0;
    m_frame.delete();
    m_sa = 0; m_ba = 0; m_sata = 1'b0;
    m_sb = 0; m_bb = 0; m_satb = 1'b0;
  endtask

  // Frame result from plain arithmetic over the whole frame.
  task automatic model_close_frame();
    int ta, tb, n;
    ta = 0; tb = 0;
    n = m_frame.size();
    foreach (m_frame[i]) begin
      ta += m_frame[i];
      tb += m_frame[i] % 8;
    end
    m_sa = (ta > 65535) ? 65535 : ta;
    m_ba = (n > 65535) ? 65535 : n;
    m_sata = (ta > 65535) || (n > 65535);
    m_sb = (tb > 15) ? 15 : tb;
    m_bb = (n > 15) ? 15 : n;
    m_satb = (tb > 15) || (n > 15);
    m_frame.delete();
  endtask

  // Apply one edge to the model using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_frame.push_back(int'(in_cnt));
      if (in_last) begin
        model_close_frame();
        m_hold = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t tbl[26];
    int   acc, cyc;

    rst = 1'b1; in_valid = 1'b0; in_cnt = 4'd0; in_last = 1'b0; out_ready = 1'b0;

    //            r v cnt l o | rdy ov sa ba sa  sb bb sb
    tbl[0]  = mk(1,0, 0,0,0,  1,0,  0,0,0,  0,0,0);
    tbl[1]  = mk(0,1, 3,0,0,  1,0,  0,0,0,  0,0,0);
    tbl[2]  = mk(0,1, 5,0,0,  1,0,  0,0,0,  0,0,0);
    tbl[3]  = mk(0,1, 0,0,0,  1,0,  0,0,0,  0,0,0);
    tbl[4]  = mk(0,1, 8,1,1,  0,1, 16,4,0,  8,4,0);
    tbl[5]  = mk(0,1, 9,0,1,  1,0, 16,4,0,  8,4,0);
    tbl[6]  = mk(0,1, 7,1,1,  0,1,  7,1,0,  7,1,0);
    tbl[7]  = mk(0,0, 0,0,0,  0,1,  7,1,0,  7,1,0);
    tbl[8]  = mk(0,1, 6,1,0,  0,1,  7,1,0,  7,1,0);
    tbl[9]  = mk(0,0, 0,0,0,  0,1,  7,1,0,  7,1,0);
    tbl[10] = mk(0,0, 0,0,0,  0,1,  7,1,0,  7,1,0);
    tbl[11] = mk(0,0, 0,0,0,  0,1,  7,1,0,  7,1,0);
    tbl[12] = mk(0,0, 0,0,1,  1,0,  7,1,0,  7,1,0);
    tbl[13] = mk(0,1, 7,0,0,  1,0,  7,1,0,  7,1,0);
    tbl[14] = mk(0,1, 7,0,0,  1,0,  7,1,0,  7,1,0);
    tbl[15] = mk(0,1, 7,1,0,  0,1, 21,3,0, 15,3,1);
    tbl[16] = mk(0,0, 0,0,1,  1,0, 21,3,0, 15,3,1);
    tbl[17] = mk(0,1, 2,1,1,  0,1,  2,1,0,  2,1,0);
    tbl[18] = mk(0,0, 0,0,1,  1,0,  2,1,0,  2,1,0);
    tbl[19] = mk(0,1, 3,0,0,  1,0,  2,1,0,  2,1,0);
    tbl[20] = mk(0,1, 4,0,0,  1,0,  2,1,0,  2,1,0);
    tbl[21] = mk(1,1, 6,0,0,  1,0,  0,0,0,  0,0,0);
    tbl[22] = mk(0,1, 5,1,0,  0,1,  5,1,0,  5,1,0);
    tbl[23] = mk(0,0, 0,0,1,  1,0,  5,1,0,  5,1,0);
    tbl[24] = mk(0,1, 1,1,0,  0,1,  1,1,0,  1,1,0);
    tbl[25] = mk(1,0, 0,0,1,  1,0,  0,0,0,  0,0,0);

    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].r; in_valid = tbl[i].v; in_cnt = 4'(tbl[i].cnt);
      in_last = tbl[i].last; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ov,
                tbl[i].e_sa, tbl[i].e_ba, tbl[i].e_sata,
                tbl[i].e_sb, tbl[i].e_bb, tbl[i].e_satb);
    end

    // Gapped 10-beat frame of ones; the block must stay ready throughout.
    rst = 1'b0; out_ready = 1'b0; in_cnt = 4'd1;
    acc = 0; cyc = 0;
    while (acc < 10 && cyc < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = (acc == 9);
      if (in_valid) acc++;
      @(posedge clk); #1;
      cyc++;
      if (acc < 10) chk("gap in_ready", 32'(in_ready_a), 32'd1);
    end
    chk("gap cycle budget", 32'(acc), 32'd10);
    in_valid = 1'b0; in_last = 1'b0;
    check_all("gap result", 1'b0, 1'b1, 10, 10, 1'b0, 10, 10, 1'b0);

    // Randomized traffic against the frame-level model.
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all("rnd reset", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_cnt    = 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 99) < 60);
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", c), !m_hold, m_hold,
                m_sa, m_ba, m_sata, m_sb, m_bb, m_satb);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
